// File: rtl/fifo_pack_drain_pkg.sv
// fifo_pack_drain_pkg
// Shared definitions for the FIFO pack/drain block: default geometry and
// the FILL/HOLD state encodings. No ports (package).

package fifo_pack_drain_pkg;

  // Default geometry: 5-bit FIFO entries packed four to a word.
  localparam int DATA_WIDTH_DEF     = 5;
  localparam int PACK_NUM_DEF       = 4;
  localparam int PACK_NUM_WIDTH_DEF = 2;

  // FILL: collecting entries from the FIFO.
  // HOLD: packed word presented on the output, waiting for acceptance.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/fifo_pack_drain_if.sv
// fifo_pack_drain_if
// Bundles the FIFO read port, the flush request and the packed-word output
// channel of fifo_pack_drain.
//   fifo_empty_i  FIFO empty flag
//   fifo_rdata_i  FIFO head entry (first-word-fall-through), valid when !fifo_empty_i
//   fifo_rd_en_o  pop FIFO head at this clock edge
//   flush_i       emit a partially filled word
//   out_valid_o   packed word valid
//   out_ready_i   consumer accepts word
//   out_data_o    packed word, lane 0 in the LSBs
//   out_cnt_o     number of valid lanes while out_valid_o, else 0
// Handshake: a word transfers on every clock edge where out_valid_o and
// out_ready_i are both high; once raised, out_valid_o, out_data_o and
// out_cnt_o hold steady until that transfer, and out_valid_o never depends
// on out_ready_i. A FIFO entry is consumed on every edge where fifo_rd_en_o
// is high, which is never the case while fifo_empty_i is high.
// master = the packing block, slave = its environment.

interface fifo_pack_drain_if
  import fifo_pack_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PACK_NUM       = PACK_NUM_DEF,
  parameter int PACK_NUM_WIDTH = PACK_NUM_WIDTH_DEF
);

  logic                           fifo_empty_i;
  logic [DATA_WIDTH-1:0]          fifo_rdata_i;
  logic                           fifo_rd_en_o;
  logic                           flush_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [PACK_NUM*DATA_WIDTH-1:0] out_data_o;
  logic [PACK_NUM_WIDTH:0]        out_cnt_o;

  modport master (
    input  fifo_empty_i, fifo_rdata_i, flush_i, out_ready_i,
    output fifo_rd_en_o, out_valid_o, out_data_o, out_cnt_o
  );

  modport slave (
    output fifo_empty_i, fifo_rdata_i, flush_i, out_ready_i,
    input  fifo_rd_en_o, out_valid_o, out_data_o, out_cnt_o
  );

endinterface

// File: rtl/fifo_pack_drain.sv
// fifo_pack_drain
// Pops narrow entries from a first-word-fall-through FIFO and packs
// PACK_NUM consecutive entries into one wide word presented on a
// valid/ready channel. flush_i emits a partially filled word early;
// unwritten lanes of a partial word read as 0.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          fifo_pack_drain_if.master (FIFO read port, flush, output channel)
//   dbg_state_o  current FSM state (ST_FILL / ST_HOLD)

module fifo_pack_drain
  import fifo_pack_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PACK_NUM       = PACK_NUM_DEF,
  parameter int PACK_NUM_WIDTH = PACK_NUM_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fifo_pack_drain_if.master bus,
  output logic [0:0]        dbg_state_o
);

  localparam logic [PACK_NUM_WIDTH-1:0] LAST_LANE = PACK_NUM_WIDTH'(PACK_NUM - 1);

  logic [0:0]                     state;
  logic [PACK_NUM_WIDTH-1:0]      cnt;
  logic [DATA_WIDTH-1:0]          lanes [PACK_NUM];
  logic [PACK_NUM_WIDTH:0]        out_cnt;
  logic [PACK_NUM*DATA_WIDTH-1:0] packed_word;

  logic                           pop;
  logic                           accept;
  logic [PACK_NUM_WIDTH:0]        eff_cnt;

  // In HOLD a pop is only allowed on the accept cycle, so the first entry of
  // the next word overlaps the handshake and sustained throughput stays at
  // one word every PACK_NUM cycles.
  assign pop     = !bus.fifo_empty_i && ((state == ST_FILL) || bus.out_ready_i);
  assign accept  = (state == ST_HOLD) && bus.out_ready_i;
  // Lanes the word would hold if it were closed at this edge.
  assign eff_cnt = {1'b0, cnt} + {{PACK_NUM_WIDTH{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FILL;
      cnt     <= '0;
      out_cnt <= '0;
      for (int i = 0; i < PACK_NUM; i++) lanes[i] <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (pop) lanes[cnt] <= bus.fifo_rdata_i;
          if (pop && (cnt == LAST_LANE)) begin
            state   <= ST_HOLD;
            out_cnt <= (PACK_NUM_WIDTH + 1)'(PACK_NUM);
            cnt     <= '0;
          end else if (bus.flush_i && (eff_cnt != '0)) begin
            // A pop on the flush edge is part of the flushed word.
            state   <= ST_HOLD;
            out_cnt <= eff_cnt;
            cnt     <= '0;
          end else if (pop) begin
            cnt <= cnt + PACK_NUM_WIDTH'(1);
          end
        end
        default: begin
          // flush_i is ignored here and not remembered.
          if (accept) begin
            state   <= ST_FILL;
            out_cnt <= '0;
            for (int i = 0; i < PACK_NUM; i++) lanes[i] <= '0;
            if (pop) begin
              lanes[0] <= bus.fifo_rdata_i;
              cnt      <= PACK_NUM_WIDTH'(1);
            end else begin
              cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < PACK_NUM; i++) packed_word[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
  end

  assign bus.fifo_rd_en_o = pop;
  assign bus.out_valid_o  = (state == ST_HOLD);
  assign bus.out_data_o   = packed_word;
  assign bus.out_cnt_o    = out_cnt;
  assign dbg_state_o      = state;

endmodule

// File: tb/tb_fifo_pack_drain.sv
// tb_fifo_pack_drain
// Bench for fifo_pack_drain. The upstream FIFO is a queue in the bench; the
// reference model tracks popped-but-unpacked entries and presented words as
// queues and closes a word when PACK_NUM entries are collected or a flush
// arrives with at least one entry. Ports: none.

module tb_fifo_pack_drain;
  import fifo_pack_drain_pkg::*;

  localparam int DW  = DATA_WIDTH_DEF;
  localparam int PN  = PACK_NUM_DEF;
  localparam int PNW = PACK_NUM_WIDTH_DEF;
  localparam int W   = DW * PN;
  localparam int OW  = 2 + (PNW + 1) + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [0:0] dbg_state;
  always #5 clk = ~clk;

  fifo_pack_drain_if ifc ();

  fifo_pack_drain dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .dbg_state_o (dbg_state)
  );

  int checks    = 0;
  int failures  = 0;
  int words_done = 0;

  // ---------------- reference model state ----------------
  logic [DW-1:0] fifo_q[$];     // upstream FIFO contents, head at [0]
  logic [DW-1:0] cur_q[$];      // entries popped but not yet in a presented word
  logic [W-1:0]  exp_q[$];      // presented word(s) awaiting acceptance
  int            exp_cnt_q[$];  // lane counts matching exp_q

  function automatic logic [W-1:0] pack_cur();
    logic [W-1:0] w;
    w = '0;
    foreach (cur_q[i]) w = w | (W'(cur_q[i]) << (i * DW));
    return w;
  endfunction

  function automatic logic m_rd_en();
    return (fifo_q.size() != 0) && ((exp_q.size() == 0) || ifc.out_ready_i);
  endfunction

  // {rd_en, valid, cnt, data}; data is only meaningful while valid.
  function automatic logic [OW-1:0] m_expect();
    if (exp_q.size() != 0)
      return {m_rd_en(), 1'b1, (PNW + 1)'(exp_cnt_q[0]), exp_q[0]};
    return {m_rd_en(), 1'b0, (PNW + 1)'(0), W'(0)};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {ifc.fifo_rd_en_o, ifc.out_valid_o, ifc.out_cnt_o,
            ifc.out_valid_o ? ifc.out_data_o : W'(0)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; presents inputs and waits for the
  // falling edge, where outputs are sampled.
  task automatic drive(input logic fl, input logic rdy);
    ifc.flush_i      = fl;
    ifc.out_ready_i  = rdy;
    ifc.fifo_empty_i = (fifo_q.size() == 0);
    ifc.fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    @(negedge clk);
  endtask

  // Applies the clock edge to the model, then moves just past the edge.
  task automatic advance();
    bit pend;
    bit pop;
    pend = (exp_q.size() != 0);
    pop  = (fifo_q.size() != 0) && (!pend || ifc.out_ready_i);
    if (pend && ifc.out_ready_i) begin
      void'(exp_q.pop_front());
      void'(exp_cnt_q.pop_front());
      words_done++;
    end
    if (pop) cur_q.push_back(fifo_q.pop_front());
    if (!pend && ((cur_q.size() == PN) || (ifc.flush_i && cur_q.size() != 0))) begin
      exp_q.push_back(pack_cur());
      exp_cnt_q.push_back(cur_q.size());
      cur_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // FIFO shows empty during reset so nothing is consumed while in reset.
  task automatic do_reset();
    rst              = 1'b1;
    ifc.flush_i      = 1'b0;
    ifc.out_ready_i  = 1'b0;
    ifc.fifo_empty_i = 1'b1;
    ifc.fifo_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cur_q.delete();
    exp_q.delete();
    exp_cnt_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst              = 1'b1;
    ifc.flush_i      = 1'b0;
    ifc.out_ready_i  = 1'b0;
    ifc.fifo_empty_i = 1'b0;
    ifc.fifo_rdata_i = 5'h1f;
    @(negedge clk);
    checks++;
    if (ifc.fifo_rd_en_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_rd_en_comb got=%b exp=1", ifc.fifo_rd_en_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o} !== {1'b0, (PNW + 1)'(0), W'(0)}) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b cnt=%0d data=%h exp 0/0/0",
               ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o);
    end
    ifc.fifo_empty_i = 1'b1;
    #1;
    checks++;
    if (ifc.fifo_rd_en_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_pop_when_empty got=%b exp=0", ifc.fifo_rd_en_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    logic [OW-1:0] obs, expv;
    do_reset();
    fifo_q = '{5'd1, 5'd2, 5'd3, 5'd4};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1);
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL single_word cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (i == 4) begin
        checks++;
        if ({ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o} !== {1'b1, 3'd4, 5'd4, 5'd3, 5'd2, 5'd1}) begin
          failures++;
          $display("FAIL single_word_value got valid=%b cnt=%0d data=%h exp 1/4/{4,3,2,1}",
                   ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] obs, expv;
    int valid_cyc[$];
    int pops;
    do_reset();
    fifo_q.delete();
    for (int v = 1; v <= 8; v++) fifo_q.push_back(DW'(v));
    pops = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1);
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (ifc.out_valid_o === 1'b1) valid_cyc.push_back(i + 1);
      if (i < 8 && ifc.fifo_rd_en_o === 1'b1) pops++;
      advance();
    end
    checks++;
    if (valid_cyc.size() != 2 || valid_cyc[0] != 5 || valid_cyc[1] != 9) begin
      failures++;
      $display("FAIL back_to_back_timing got %0d valid cycles first=%0d exp cycles 5 and 9",
               valid_cyc.size(), (valid_cyc.size() != 0) ? valid_cyc[0] : -1);
    end
    checks++;
    if (pops != 8) begin
      failures++;
      $display("FAIL back_to_back_pops got=%0d exp=8", pops);
    end
  endtask

  task automatic test_flush();
    logic [OW-1:0] obs, expv;
    bit fl_pat[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    do_reset();
    fifo_q = '{5'd7, 5'd8, 5'd9};
    for (int i = 0; i < 8; i++) begin
      drive(fl_pat[i], 1'b1);
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL flush cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (i == 4) begin
        checks++;
        if ({ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o} !== {1'b1, 3'd3, 5'd0, 5'd9, 5'd8, 5'd7}) begin
          failures++;
          $display("FAIL flush_partial got valid=%b cnt=%0d data=%h exp 1/3/{0,9,8,7}",
                   ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o);
        end
      end
      if (i == 6) begin
        checks++;
        if (ifc.out_valid_o !== 1'b0) begin
          failures++;
          $display("FAIL flush_empty_ignored got valid=%b exp=0", ifc.out_valid_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_flush_with_pop();
    logic [OW-1:0] obs, expv;
    bit fl_pat[4] = '{0, 1, 0, 0};
    do_reset();
    fifo_q = '{5'd5, 5'd6};
    for (int i = 0; i < 4; i++) begin
      drive(fl_pat[i], 1'b1);
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL flush_with_pop cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (i == 2) begin
        checks++;
        if ({ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o} !== {1'b1, 3'd2, 5'd0, 5'd0, 5'd6, 5'd5}) begin
          failures++;
          $display("FAIL flush_with_pop_value got valid=%b cnt=%0d data=%h exp 1/2/{0,0,6,5}",
                   ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] obs, expv;
    logic rdy;
    do_reset();
    fifo_q = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11};
    for (int i = 0; i < 12; i++) begin
      rdy = !(i >= 4 && i <= 8);
      drive(1'b0, rdy);
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (i >= 4 && i <= 8) begin
        checks++;
        if ({ifc.fifo_rd_en_o, ifc.out_valid_o, ifc.out_data_o} !== {1'b0, 1'b1, 5'd4, 5'd3, 5'd2, 5'd1}) begin
          failures++;
          $display("FAIL backpressure_stall cyc=%0d got rd_en=%b valid=%b data=%h exp 0/1/{4,3,2,1}",
                   i, ifc.fifo_rd_en_o, ifc.out_valid_o, ifc.out_data_o);
        end
      end
      if (i == 9) begin
        checks++;
        if (ifc.fifo_rd_en_o !== 1'b1) begin
          failures++;
          $display("FAIL backpressure_accept_pop got rd_en=%b exp=1", ifc.fifo_rd_en_o);
        end
      end
      if (i == 10) begin
        checks++;
        if (ifc.out_data_o !== W'(10)) begin
          failures++;
          $display("FAIL backpressure_lane0_load got data=%h exp=%h", ifc.out_data_o, W'(10));
        end
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    logic [OW-1:0] obs, expv;
    do_reset();
    fifo_q = '{5'd11, 5'd12, 5'd21, 5'd22, 5'd23, 5'd24};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1);
      advance();
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1);
      if (i == 0) begin
        checks++;
        if ({ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o} !== {1'b0, (PNW + 1)'(0), W'(0)}) begin
          failures++;
          $display("FAIL mid_reset_cleared got valid=%b cnt=%0d data=%h exp 0/0/0",
                   ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o);
        end
      end
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL mid_reset cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      if (i == 4) begin
        checks++;
        if ({ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o} !== {1'b1, 3'd4, 5'd24, 5'd23, 5'd22, 5'd21}) begin
          failures++;
          $display("FAIL mid_reset_clean_word got valid=%b cnt=%0d data=%h exp 1/4/{24,23,22,21}",
                   ifc.out_valid_o, ifc.out_cnt_o, ifc.out_data_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] obs, expv;
    int start_words;
    do_reset();
    fifo_q.delete();
    start_words = words_done;
    for (int i = 0; i < 600; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) fifo_q.push_back(DW'($urandom));
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      obs = observed(); expv = m_expect();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      advance();
    end
    checks++;
    if (words_done - start_words < 20) begin
      failures++;
      $display("FAIL random_progress got=%0d words exp>=20", words_done - start_words);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_flush();
    test_flush_with_pop();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
